// File: rtl/svm_rom_streamer.sv
// Streaming read controller for the SVM support-vector ROM bank array.
// Optional build macro SVM_ROM_CEB_GATE_EN: deselect banks on non-issuing cycles.
module svm_rom_streamer #(
   parameter int unsigned NUM_BANKS     = 16,
   parameter int unsigned BANK_WIDTH    = 128,
   parameter int unsigned ROM_DEPTH     = 1024,
   parameter int unsigned LOG_ROM_DEPTH = $clog2(ROM_DEPTH),
   parameter int unsigned FIFO_DEPTH    = 2
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              start,
   input  logic [LOG_ROM_DEPTH-1:0]          base_addr,
   input  logic [LOG_ROM_DEPTH:0]            num_rows,
   output logic                              busy,
   output logic                              done,
   output logic                              rom_ceb,
   output logic [LOG_ROM_DEPTH-1:0]          rom_addr,
   input  logic [NUM_BANKS*BANK_WIDTH-1:0]   rom_q,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [NUM_BANKS*BANK_WIDTH-1:0]   out_data,
   output logic [LOG_ROM_DEPTH-1:0]          out_row_idx,
   output logic                              out_last
);

   localparam int unsigned DW = NUM_BANKS * BANK_WIDTH;
   localparam int unsigned AW = LOG_ROM_DEPTH;
   localparam int unsigned NW = LOG_ROM_DEPTH + 1;
   localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned OW = CW + 1;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t          state_q, state_d;
   logic [NW-1:0]   num_q, issued_q, issued_nxt;
   logic [AW-1:0]   addr_q, addr_nxt;
   logic            inflight_q;
   logic [AW-1:0]   tag_idx_q;
   logic            tag_last_q;
   logic            busy_q, done_q;
   logic            issue, pop, push;
   logic [OW-1:0]   occ;

   logic [DW-1:0]   mem_data [FIFO_DEPTH];
   logic [AW-1:0]   mem_idx  [FIFO_DEPTH];
   logic            mem_last [FIFO_DEPTH];
   logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]   count_q;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign issued_nxt = issued_q + NW'(1);
   assign addr_nxt   = (addr_q == AW'(ROM_DEPTH - 1)) ? '0 : addr_q + AW'(1);
   assign pop        = out_valid & out_ready;
   assign push       = inflight_q;
   // Slots already committed after this cycle's pop; a same-cycle pop frees a slot.
   assign occ        = OW'(count_q) + OW'(inflight_q) - OW'(pop);

   // Next-state and issue decision
   always_comb begin
      state_d = state_q;
      issue   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) state_d = (num_rows == '0) ? DONE : RUN;
         end
         RUN: begin
            if ((issued_q < num_q) && (occ < OW'(FIFO_DEPTH))) begin
               issue = 1'b1;
               if (issued_nxt == num_q) state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (!inflight_q && ((count_q == '0) || ((count_q == CW'(1)) && pop)))
               state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Control and issue bookkeeping
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         num_q      <= '0;
         issued_q   <= '0;
         addr_q     <= '0;
         inflight_q <= 1'b0;
         tag_idx_q  <= '0;
         tag_last_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         busy_q     <= (state_d == RUN) || (state_d == DRAIN);
         done_q     <= (state_d == DONE);
         inflight_q <= issue;
         if ((state_q == IDLE) && start && (num_rows != '0)) begin
            addr_q   <= base_addr;
            num_q    <= num_rows;
            issued_q <= '0;
         end else if (issue) begin
            addr_q     <= addr_nxt;
            issued_q   <= issued_nxt;
            tag_idx_q  <= AW'(issued_q);
            tag_last_q <= (issued_nxt == num_q);
         end
      end
   end

   // Output buffer: captures ROM data the cycle after each issue
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            mem_data[i] <= '0;
            mem_idx[i]  <= '0;
            mem_last[i] <= 1'b0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            mem_data[wr_ptr_q] <= rom_q;
            mem_idx[wr_ptr_q]  <= tag_idx_q;
            mem_last[wr_ptr_q] <= tag_last_q;
            wr_ptr_q           <= ptr_inc(wr_ptr_q);
         end
         if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
         case ({push, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign rom_addr    = addr_q;
   assign out_valid   = (count_q != '0);
   assign out_data    = mem_data[rd_ptr_q];
   assign out_row_idx = mem_idx[rd_ptr_q];
   assign out_last    = mem_last[rd_ptr_q];

`ifdef SVM_ROM_CEB_GATE_EN
   assign rom_ceb = ~issue;
`else
   assign rom_ceb = 1'b0;
`endif

endmodule

// File: tb/tb_svm_rom_streamer.sv
// Bench for svm_rom_streamer: randomized runs checked against a row-list model.
module tb_svm_rom_streamer;

   localparam int NB = 16;
   localparam int BW = 128;
   localparam int DW = NB * BW;
   localparam int DEPTH = 1024;

   logic            clk, rst_n, start;
   logic [9:0]      base_addr;
   logic [10:0]     num_rows;
   logic            busy, done, rom_ceb;
   logic [9:0]      rom_addr;
   logic [DW-1:0]   rom_q;
   logic            out_valid, out_ready;
   logic [DW-1:0]   out_data;
   logic [9:0]      out_row_idx;
   logic            out_last;

   int errors = 0;
   int checks = 0;

   svm_rom_streamer dut (
      .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
      .num_rows(num_rows), .busy(busy), .done(done), .rom_ceb(rom_ceb),
      .rom_addr(rom_addr), .rom_q(rom_q), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_row_idx(out_row_idx),
      .out_last(out_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [DW-1:0] pat(input int r);
      logic [DW-1:0] d;
      d = '0;
      for (int b = 0; b < NB; b++)
         d[(NB-1-b)*BW +: BW] = {16'(b), 16'(r), 32'(r * 32'h9E37_79B1),
                                 64'hC0DE_0000_0000_0000 | 64'(r)};
      return d;
   endfunction

   // ROM macro model: one-cycle read latency, holds output while deselected
   initial rom_q = '0;
   always @(posedge clk) if (!rom_ceb) rom_q <= pat(int'(rom_addr));

   typedef struct {
      logic [DW-1:0] data;
      logic [9:0]    idx;
      logic          last;
      int            cyc;
   } beat_t;

   beat_t beats[$];
   int first_valid, done_cyc, done_cnt, busy_cnt, busy_in_done, stab_err;
   int ahead_max, ceb_low, ceb_high, ceb_addr_err, timed_out, extra_valid;

   function automatic logic ready_for(input int mode, input int cyc);
      if (mode == 0) return 1'b1;
      if (cyc >= 6 && cyc < 16) return 1'b0;
      return 1'($urandom_range(0, 1));
   endfunction

   // Drives one run and records what the DUT presents; comparisons live in the tests
   task automatic drive_run(input int base, input int n, input int rmode,
                            input int dup_at, input int abort_at);
      int cyc, acc, ah;
      logic pv, pr, pl;
      logic [DW-1:0] pd;
      logic [9:0] pi;
      beats.delete();
      first_valid = -1; done_cyc = -1; done_cnt = 0; busy_cnt = 0;
      busy_in_done = 0; stab_err = 0; ahead_max = 0; ceb_low = 0; ceb_high = 0;
      ceb_addr_err = 0; timed_out = 0; extra_valid = 0;
      pv = 1'b0; pr = 1'b0; pd = '0; pi = '0; pl = 1'b0;
      base_addr = 10'(base);
      num_rows  = 11'(n);
      start     = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cyc = 1; acc = 0;
      forever begin
         if (abort_at > 0 && beats.size() == abort_at) begin
            rst_n = 1'b0;
            #1;
            return;
         end
         if (cyc == dup_at) begin
            start = 1'b1; base_addr = 10'(base + 100); num_rows = 11'd3;
         end else start = 1'b0;
         out_ready = ready_for(rmode, cyc);
         #1;
         if (pv && !pr && (!out_valid || out_data !== pd || out_row_idx !== pi || out_last !== pl))
            stab_err++;
         if (out_valid && first_valid < 0) first_valid = cyc;
         if (busy) begin
            busy_cnt++;
            ah = ((int'(rom_addr) - base) % DEPTH + DEPTH) % DEPTH - acc;
            if (ah > ahead_max) ahead_max = ah;
         end
         if (!rom_ceb) begin
            ceb_low++;
            if (rom_addr !== 10'((base + ceb_low - 1) % DEPTH)) ceb_addr_err++;
         end else ceb_high++;
         if (done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = cyc;
            if (busy) busy_in_done++;
         end
         if (out_valid && done_cyc >= 0) extra_valid++;
         if (out_valid && out_ready) begin
            beats.push_back('{out_data, out_row_idx, out_last, cyc});
            acc++;
         end
         pv = out_valid; pr = out_ready; pd = out_data; pi = out_row_idx; pl = out_last;
         if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
         if (cyc >= 30 * n + 100) begin timed_out = 1; break; end
         cyc++;
         @(posedge clk); #1;
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
      checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_last got=%b exp=0", out_last); end
      checks++; if (out_row_idx !== 10'd0) begin errors++; $display("FAIL reset_idx got=%0d exp=0", out_row_idx); end
      checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_data got=%h exp=0", out_data[63:0]); end
      checks++; if (rom_addr !== 10'd0) begin errors++; $display("FAIL reset_addr got=%0d exp=0", rom_addr); end
`ifdef SVM_ROM_CEB_GATE_EN
      checks++; if (rom_ceb !== 1'b1) begin errors++; $display("FAIL reset_ceb got=%b exp=1", rom_ceb); end
`else
      checks++; if (rom_ceb !== 1'b0) begin errors++; $display("FAIL reset_ceb got=%b exp=0", rom_ceb); end
`endif
   endtask

   // Compares the recorded beats with rows base..base+n-1 (wrapping)
   task automatic test_stream(input string name, input int base, input int n, input int rmode);
      drive_run(base, n, rmode, 0, 0);
      checks++; if (timed_out != 0) begin errors++; $display("FAIL %s_timeout got=%0d exp=0", name, timed_out); end
      checks++; if (beats.size() != n) begin errors++; $display("FAIL %s_count got=%0d exp=%0d", name, beats.size(), n); end
      for (int i = 0; i < beats.size() && i < n; i++) begin
         checks++;
         if (beats[i].data !== pat((base + i) % DEPTH)) begin
            errors++; $display("FAIL %s_data beat=%0d got=%h exp=%h", name, i, beats[i].data[63:0], pat((base + i) % DEPTH) >> 0);
         end
         checks++;
         if (beats[i].idx !== 10'(i)) begin errors++; $display("FAIL %s_idx beat=%0d got=%0d exp=%0d", name, i, beats[i].idx, i); end
         checks++;
         if (beats[i].last !== (i == n - 1)) begin errors++; $display("FAIL %s_last beat=%0d got=%b exp=%b", name, i, beats[i].last, i == n - 1); end
      end
      checks++; if (done_cnt != 1) begin errors++; $display("FAIL %s_done_pulses got=%0d exp=1", name, done_cnt); end
      checks++; if (busy_in_done != 0) begin errors++; $display("FAIL %s_busy_in_done got=%0d exp=0", name, busy_in_done); end
      checks++; if (busy_cnt != done_cyc - 1) begin errors++; $display("FAIL %s_busy_cycles got=%0d exp=%0d", name, busy_cnt, done_cyc - 1); end
      checks++; if (stab_err != 0) begin errors++; $display("FAIL %s_stable got=%0d exp=0", name, stab_err); end
      checks++; if (ahead_max > 2) begin errors++; $display("FAIL %s_ahead got=%0d exp<=2", name, ahead_max); end
      checks++; if (extra_valid != 0) begin errors++; $display("FAIL %s_extra_valid got=%0d exp=0", name, extra_valid); end
      if (beats.size() > 0) begin
         checks++;
         if (done_cyc != beats[beats.size()-1].cyc + 1) begin
            errors++; $display("FAIL %s_done_time got=%0d exp=%0d", name, done_cyc, beats[beats.size()-1].cyc + 1);
         end
      end
`ifdef SVM_ROM_CEB_GATE_EN
      checks++; if (ceb_low != n) begin errors++; $display("FAIL %s_ceb_low got=%0d exp=%0d", name, ceb_low, n); end
      checks++; if (ceb_addr_err != 0) begin errors++; $display("FAIL %s_ceb_addr got=%0d exp=0", name, ceb_addr_err); end
`else
      checks++; if (ceb_high != 0) begin errors++; $display("FAIL %s_ceb_high got=%0d exp=0", name, ceb_high); end
`endif
   endtask

   task automatic test_basic();
      test_stream("basic", 5, 4, 0);
      checks++; if (first_valid != 3) begin errors++; $display("FAIL basic_latency got=%0d exp=3", first_valid); end
      if (beats.size() == 4) begin
         checks++;
         if (beats[3].cyc - beats[0].cyc != 3) begin errors++; $display("FAIL basic_rate got=%0d exp=3", beats[3].cyc - beats[0].cyc); end
      end
   endtask

   task automatic test_wrap();
      test_stream("wrap", 1022, 4, 0);
   endtask

   task automatic test_backpressure();
      test_stream("bp", int'($urandom_range(0, DEPTH - 1)), 8, 1);
      for (int k = 0; k < 4; k++)
         test_stream("rand", int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, 12)), int'(k % 2));
   endtask

   task automatic test_zero();
      drive_run(int'($urandom_range(0, DEPTH - 1)), 0, 0, 0, 0);
      checks++; if (beats.size() != 0) begin errors++; $display("FAIL zero_beats got=%0d exp=0", beats.size()); end
      checks++; if (done_cyc != 1) begin errors++; $display("FAIL zero_done_time got=%0d exp=1", done_cyc); end
      checks++; if (done_cnt != 1) begin errors++; $display("FAIL zero_done_pulses got=%0d exp=1", done_cnt); end
      checks++; if (busy_cnt != 0) begin errors++; $display("FAIL zero_busy got=%0d exp=0", busy_cnt); end
`ifdef SVM_ROM_CEB_GATE_EN
      checks++; if (ceb_low != 0) begin errors++; $display("FAIL zero_ceb_low got=%0d exp=0", ceb_low); end
`endif
   endtask

   task automatic test_full();
      int bad, lasts;
      drive_run(0, DEPTH, 0, 0, 0);
      bad = 0; lasts = 0;
      for (int i = 0; i < beats.size(); i++) begin
         if (beats[i].data !== pat(i % DEPTH) || beats[i].idx !== 10'(i)) bad++;
         if (beats[i].last === 1'b1) begin
            lasts++;
            if (i != DEPTH - 1) bad++;
         end
      end
      checks++; if (beats.size() != DEPTH) begin errors++; $display("FAIL full_count got=%0d exp=%0d", beats.size(), DEPTH); end
      checks++; if (bad != 0) begin errors++; $display("FAIL full_content got=%0d bad exp=0", bad); end
      checks++; if (lasts != 1) begin errors++; $display("FAIL full_last got=%0d exp=1", lasts); end
      checks++; if (done_cnt != 1) begin errors++; $display("FAIL full_done got=%0d exp=1", done_cnt); end
   endtask

   task automatic test_start_busy();
      int base;
      base = int'($urandom_range(0, DEPTH - 1));
      drive_run(base, 10, 0, 3, 0);
      checks++; if (beats.size() != 10) begin errors++; $display("FAIL dup_count got=%0d exp=10", beats.size()); end
      for (int i = 0; i < beats.size() && i < 10; i++) begin
         checks++;
         if (beats[i].data !== pat((base + i) % DEPTH) || beats[i].idx !== 10'(i)) begin
            errors++; $display("FAIL dup_beat beat=%0d got_idx=%0d exp_idx=%0d", i, beats[i].idx, i);
         end
      end
      checks++; if (done_cnt != 1 || extra_valid != 0) begin errors++; $display("FAIL dup_end got_done=%0d got_extra=%0d exp=1,0", done_cnt, extra_valid); end
   endtask

   task automatic test_reset_mid();
      int dseen;
      drive_run(int'($urandom_range(0, DEPTH - 1)), 10, 0, 0, 3);
      test_reset();
      dseen = 0;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) dseen++;
      end
      checks++; if (dseen != 0) begin errors++; $display("FAIL midreset_quiet got=%0d exp=0", dseen); end
      rst_n = 1'b1;
      @(posedge clk); #1;
      test_basic();
   endtask

   initial begin
      rst_n = 1'b1; start = 1'b0; out_ready = 1'b0; base_addr = '0; num_rows = '0;
      #3 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      rst_n = 1'b1;
      @(posedge clk); #1;
      test_basic();
      test_wrap();
      test_backpressure();
      test_zero();
      test_full();
      test_start_busy();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
